// File: rtl/seq_restoring_divider.sv
// rtl/seq_restoring_divider.sv - iterative unsigned restoring divider, one quotient bit per clock
module seq_restoring_divider #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH:0]   r_q, r_d;
    logic [WIDTH-1:0] qs_q, qs_d;
    logic [WIDTH-1:0] dv_q, dv_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   step_r;
    logic [WIDTH-1:0] step_q;

    // Shift the next dividend bit into the partial remainder and try subtracting the divisor.
    assign shifted = {r_q[WIDTH-1:0], qs_q[WIDTH-1]};
    assign trial   = shifted - {1'b0, dv_q};

    always_comb begin
        if (!trial[WIDTH]) begin
            step_r = trial;
            step_q = {qs_q[WIDTH-2:0], 1'b1};
        end else begin
            step_r = shifted;
            step_q = {qs_q[WIDTH-2:0], 1'b0};
        end
    end

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        qs_d    = qs_q;
        dv_d    = dv_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (divisor != '0) begin
                        qs_d    = dividend;
                        dv_d    = divisor;
                        r_d     = '0;
                        cnt_d   = CNT_W'(WIDTH);
                        state_d = S_CALC;
                    end else begin
                        quot_d  = '1;
                        rem_d   = dividend;
                        dbz_d   = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_CALC: begin
                r_d   = step_r;
                qs_d  = step_q;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    quot_d  = step_q;
                    rem_d   = step_r[WIDTH-1:0];
                    dbz_d   = 1'b0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            r_q     <= '0;
            qs_q    <= '0;
            dv_q    <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            qs_q    <= qs_d;
            dv_q    <= dv_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = (state_q == S_CALC);
    assign done        = (state_q == S_DONE);
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// tb/tb_seq_restoring_divider.sv - scoreboard bench for seq_restoring_divider
module tb_seq_restoring_divider;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         busy;
    logic         done;
    logic         div_by_zero;

    seq_restoring_divider #(.WIDTH(W), .CNT_W(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    int           n_checks = 0;
    int           n_pass   = 0;
    logic [2*W:0] exp_q[$];
    logic [2*W:0] mon_e;
    logic [2*W:0] snap;
    logic         snap_valid = 1'b0;
    logic         prev_done  = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    // {div_by_zero, quotient, remainder}
    function automatic logic [2*W:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
        if (b == '0) return {1'b1, {W{1'b1}}, a};
        return {1'b0, W'(a / b), W'(a % b)};
    endfunction

    always @(negedge clk) begin
        if (done) begin
            check("done_width", 32'(prev_done), 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("quotient", 32'(quotient), 32'(mon_e[2*W-1:W]));
                check("remainder", 32'(remainder), 32'(mon_e[W-1:0]));
                check("div_by_zero", 32'(div_by_zero), 32'(mon_e[2*W]));
            end
            snap       = {div_by_zero, quotient, remainder};
            snap_valid = 1'b1;
        end else if (snap_valid) begin
            check("hold", 32'({div_by_zero, quotient, remainder}), 32'(snap));
        end
        prev_done = done;
    end

    task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b);
        int lat;
        int busy_n;
        logic seen;
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        exp_q.push_back(model(a, b));
        @(negedge clk);
        start    = 1'b0;
        dividend = W'($urandom);
        divisor  = W'($urandom);
        lat      = 1;
        busy_n   = int'(busy);
        seen     = done;
        while (!seen && lat < 20) begin
            @(negedge clk);
            lat++;
            busy_n += int'(busy);
            seen = done;
        end
        check("done_seen", 32'(seen), 32'd1);
        if (seen) check("latency", 32'(lat), (b == '0) ? 32'd1 : 32'(W + 1));
        check("busy_cycles", 32'(busy_n), (b == '0) ? 32'd0 : 32'(W));
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_quotient", 32'(quotient), 32'd0);
        check("rst_remainder", 32'(remainder), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_dbz", 32'(div_by_zero), 32'd0);

        run_div(8'd200, 8'd7);
        run_div(8'd255, 8'd1);
        run_div(8'd5, 8'd9);
        run_div(8'd0, 8'd3);
        run_div(8'd255, 8'd255);
        run_div(8'd128, 8'd2);
        run_div(8'd100, 8'd0);
        run_div(8'd9, 8'd3);

        // start held high with operands changing each cycle
        for (int k = 0; k <= 2 * W + 3; k++) begin
            @(negedge clk);
            if (k > 0) check("stream_done", 32'(done), 32'((k % (W + 2)) == W + 1));
            if (k == 2 * W + 3) begin
                start = 1'b0;
            end else begin
                start    = 1'b1;
                dividend = (k == 0) ? 8'd200 : W'($urandom);
                divisor  = (k == 0) ? 8'd7 : W'($urandom_range(1, 255));
                if ((k % (W + 2)) == 0) exp_q.push_back(model(dividend, divisor));
            end
        end

        // reset in the middle of a calculation
        @(negedge clk);
        dividend = 8'd200;
        divisor  = 8'd7;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n      = 1'b0;
        snap_valid = 1'b0;
        @(negedge clk);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_quotient", 32'(quotient), 32'd0);
        check("mid_rst_remainder", 32'(remainder), 32'd0);
        check("mid_rst_dbz", 32'(div_by_zero), 32'd0);
        rst_n = 1'b1;
        run_div(8'd50, 8'd6);

        for (int i = 0; i < 3000; i++) begin
            run_div(W'($urandom), W'($urandom_range(0, 255)));
        end
        for (int b = 0; b < 256; b++) begin
            run_div(W'($urandom), W'(b));
        end

        repeat (3) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
